// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: 11-state Moore FSM with combinational
// ImmSrc/ALUControl decode and a branch-qualified PCWrite.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   state_t     cur_state;
   state_t     nxt_state;
   logic [1:0] alu_op;
   logic       pc_update;
   logic       branch;

   // NOTE: sequential state uses non-blocking assignment so every register
   // samples pre-edge values; the async reset pulls FETCH in without a clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cur_state <= FETCH;
      else       cur_state <= nxt_state;
   end

   assign state = cur_state;

   // NOTE: every combinational output gets a default before the case so no
   // path leaves a signal unassigned and a latch is never inferred.
   always_comb begin
      nxt_state = FETCH;
      unique case (cur_state)
         FETCH:    nxt_state = DECODE;
         DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: nxt_state = MEMADR;
               OP_RTYPE:          nxt_state = EXECUTER;
               OP_ITYPE:          nxt_state = EXECUTEI;
               OP_BEQ:            nxt_state = BEQ;
               OP_JAL:            nxt_state = JAL;
               default:           nxt_state = FETCH;
            endcase
         end
         MEMADR:   nxt_state = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
         MEMREAD:  nxt_state = MEMWB;
         EXECUTER, EXECUTEI, JAL: nxt_state = ALUWB;
         default:  nxt_state = FETCH;
      endcase
   end

   always_comb begin
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegWrite  = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      alu_op    = 2'b00;
      pc_update = 1'b0;
      branch    = 1'b0;
      case (cur_state)
         FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            pc_update = 1'b1;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         MEMREAD:  AdrSrc = 1'b1;
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         EXECUTER: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b10;
         end
         EXECUTEI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            alu_op  = 2'b10;
         end
         ALUWB:    RegWrite = 1'b1;
         BEQ: begin
            ALUSrcA = 2'b10;
            alu_op  = 2'b01;
            branch  = 1'b1;
         end
         JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // zero is combinational here so a taken beq updates the PC on the BEQ edge
   assign PCWrite = pc_update | (branch & zero);

   always_comb begin
      case (op)
         OP_STORE: ImmSrc = 2'b01;
         OP_BEQ:   ImmSrc = 2'b10;
         OP_JAL:   ImmSrc = 2'b11;
         default:  ImmSrc = 2'b00;
      endcase
   end

   always_comb begin
      ALUControl = 3'b000;
      case (alu_op)
         2'b01: ALUControl = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b110:  ALUControl = 3'b011;
               3'b111:  ALUControl = 3'b010;
               default: ALUControl = 3'b000;
            endcase
         end
         default: ALUControl = 3'b000;
      endcase
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the FSM to FETCH immediately, independent of clk.
REQ-004 op  input  7  instruction opcode (instr[6:0]).
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 zero  input  1  ALU zero flag.
REQ-008 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables and selects.
REQ-009 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-010 ALUControl  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or.
REQ-011 state  output  4  current FSM state, for debug.

Function
REQ-012 The FSM SHALL use 11 states encoded FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-013 Transitions: FETCH->DECODE; MEMREAD->MEMWB; MEMWB, MEMWRITE, BEQ->FETCH; EXECUTER, EXECUTEI, JAL->ALUWB; ALUWB->FETCH.
REQ-014 DECODE SHALL branch on op: 0000011 or 0100011->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1100011->BEQ, 1101111->JAL; any other op->FETCH.
REQ-015 MEMADR SHALL go to MEMREAD for op=0000011 and to MEMWRITE otherwise.
REQ-016 All outputs except ImmSrc and ALUControl SHALL be Moore outputs of state; any output not listed for a state SHALL be 0.
REQ-017 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1.
REQ-018 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-019 MEMREAD: ResultSrc=00, AdrSrc=1. MEMWB: ResultSrc=01, RegWrite=1. MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
REQ-020 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. ALUWB: ResultSrc=00, RegWrite=1.
REQ-021 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-022 PCWrite SHALL equal PCUpdate OR (Branch AND zero), combinationally, so zero sampled in BEQ takes effect on the same edge.
REQ-023 ImmSrc SHALL decode combinationally from op: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, other->00.
REQ-024 ALUControl SHALL decode combinationally: ALUOp 00->000; 01->001; 10 with funct3 000->001 if (op[5] AND funct7b5), else 000; funct3 110->011; funct3 111->010; any other funct3 or ALUOp 11->000.
REQ-025 ALUOp, PCUpdate and Branch SHALL be internal only.
REQ-026 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type, jal 4 cycles; beq 3 cycles; unknown op 2 cycles.

Reset
REQ-027 While reset=1, state SHALL be FETCH (0) and outputs SHALL show FETCH values: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10, all other Moore outputs 0.
REQ-028 Reset asserted in any state mid-instruction SHALL abort it with no further MemWrite/RegWrite; after release, the first rising edge SHALL move FETCH->DECODE.

Verification
REQ-029 Reset, then lw (op=0000011) -> state sequence 0,1,2,3,4,0; MemWrite=0 throughout; RegWrite=1 only in state 4, with ResultSrc=01.
REQ-030 sw (op=0100011) -> 0,1,2,5,0; MemWrite=1 and AdrSrc=1 only in state 5; ImmSrc=01.
REQ-031 R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER; or (funct3=110) -> 011; addi (op=0010011, funct7b5=1) -> 000.
REQ-032 beq with zero=1 -> PCWrite=1 in BEQ, then FETCH; with zero=0 -> PCWrite=0 in BEQ; ALUControl=001 in both cases.
REQ-033 jal -> 0,1,10,8,0; PCWrite=1 in JAL; RegWrite=1 in ALUWB; ImmSrc=11.
REQ-034 op=1111111 -> DECODE->FETCH; reset pulsed asynchronously mid-EXECUTER -> state=0 before the next edge, and no RegWrite pulse occurs.
